// File: rtl/timing_sequencer.sv
// One-hot t1..t8 cycle sequencer and opcode latch for the M6502 core.
// Interrupt injection (NMI edge / IRQ level -> BRK) is built only when M6502_INTERRUPT_EN is defined.
module timing_sequencer #(
    parameter int unsigned TIMING_WIDTH = 8,
    parameter logic [7:0]  RESET_OPCODE = 8'hEA,
    parameter logic [7:0]  BRK_OPCODE   = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    rdy,
    input  logic                    write_en,
    input  logic                    timing_reset,
    input  logic [7:0]              data_in,
    input  logic                    irq_n,
    input  logic                    nmi_n,
    input  logic                    i_flag,
    output logic [TIMING_WIDTH-1:0] timing,
    output logic [7:0]              opcode,
    output logic                    sync,
    output logic                    int_active,
    output logic [1:0]              vector_sel,
    output logic                    jam
);

    localparam logic [TIMING_WIDTH-1:0] T1_STATE   = {{(TIMING_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]              VEC_NONE   = 2'b00;
    localparam logic [1:0]              VEC_NMI    = 2'b01;
    localparam logic [1:0]              VEC_IRQ    = 2'b11;

    logic [TIMING_WIDTH-1:0] timing_q, timing_d;
    logic [7:0]              opcode_q, opcode_d;
    logic                    jam_q, jam_d;
    logic                    advance;
    logic                    fetch;

    // Write cycles cannot be stretched, so they advance even with rdy low.
    assign advance = (rdy | write_en) & ~jam_q;
    assign fetch   = advance & timing_q[0];

    always_comb begin
        timing_d = timing_q;
        jam_d    = jam_q;
        if (advance) begin
            if (timing_reset) begin
                timing_d = T1_STATE;
            end else if (timing_q[TIMING_WIDTH-1]) begin
                timing_d = '0;
                jam_d    = 1'b1;
            end else begin
                timing_d = timing_q << 1;
            end
        end
    end

`ifdef M6502_INTERRUPT_EN
    logic       nmi_n_q;
    logic       nmi_pending_q, nmi_pending_d;
    logic       int_active_q, int_active_d;
    logic [1:0] vector_sel_q, vector_sel_d;
    logic       inject_nmi, inject_irq;

    assign inject_nmi = fetch & nmi_pending_q;
    assign inject_irq = fetch & ~nmi_pending_q & ~irq_n & ~i_flag;

    always_comb begin
        opcode_d      = opcode_q;
        int_active_d  = int_active_q;
        vector_sel_d  = vector_sel_q;
        nmi_pending_d = nmi_pending_q;
        if (fetch) begin
            opcode_d = (inject_nmi | inject_irq) ? BRK_OPCODE : data_in;
        end
        if (advance & timing_reset & int_active_q) begin
            int_active_d = 1'b0;
            vector_sel_d = VEC_NONE;
        end
        if (inject_nmi) begin
            int_active_d  = 1'b1;
            vector_sel_d  = VEC_NMI;
            nmi_pending_d = 1'b0;
        end else if (inject_irq) begin
            int_active_d = 1'b1;
            vector_sel_d = VEC_IRQ;
        end
        // A fresh falling edge overrides the clear from a same-cycle NMI injection.
        if (nmi_n_q & ~nmi_n) begin
            nmi_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            nmi_n_q       <= 1'b1;
            nmi_pending_q <= 1'b0;
            int_active_q  <= 1'b0;
            vector_sel_q  <= VEC_NONE;
        end else begin
            nmi_n_q       <= nmi_n;
            nmi_pending_q <= nmi_pending_d;
            int_active_q  <= int_active_d;
            vector_sel_q  <= vector_sel_d;
        end
    end

    assign int_active = int_active_q;
    assign vector_sel = vector_sel_q;
`else
    logic unused_int_inputs;
    assign unused_int_inputs = &{1'b0, irq_n, nmi_n, i_flag};

    always_comb begin
        opcode_d = opcode_q;
        if (fetch) begin
            opcode_d = data_in;
        end
    end

    assign int_active = 1'b0;
    assign vector_sel = VEC_NONE;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timing_q <= T1_STATE;
            opcode_q <= RESET_OPCODE;
            jam_q    <= 1'b0;
        end else begin
            timing_q <= timing_d;
            opcode_q <= opcode_d;
            jam_q    <= jam_d;
        end
    end

    assign timing = timing_q;
    assign opcode = opcode_q;
    assign jam    = jam_q;
    assign sync   = timing_q[0];

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: driver queues hand-computed post-edge state,
// monitor pops and compares one entry per clock. Interrupt vectors follow M6502_INTERRUPT_EN.
module tb_timing_sequencer;

    typedef struct {
        string      name;
        logic [7:0] timing;
        logic [7:0] opcode;
        logic       jam;
        logic       int_active;
        logic [1:0] vector_sel;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rdy = 1'b0;
    logic       write_en = 1'b0;
    logic       timing_reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       irq_n = 1'b1;
    logic       nmi_n = 1'b1;
    logic       i_flag = 1'b1;
    logic [7:0] timing;
    logic [7:0] opcode;
    logic       sync;
    logic       int_active;
    logic [1:0] vector_sel;
    logic       jam;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    timing_sequencer #(
        .TIMING_WIDTH(8),
        .RESET_OPCODE(8'hEA),
        .BRK_OPCODE(8'h00)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rdy(rdy),
        .write_en(write_en),
        .timing_reset(timing_reset),
        .data_in(data_in),
        .irq_n(irq_n),
        .nmi_n(nmi_n),
        .i_flag(i_flag),
        .timing(timing),
        .opcode(opcode),
        .sync(sync),
        .int_active(int_active),
        .vector_sel(vector_sel),
        .jam(jam)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input string field, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%02h required=%02h", name, field, act, req);
        end
    endtask

    // Monitor: one queued expectation per clock edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "timing", timing, e.timing);
            check(e.name, "opcode", opcode, e.opcode);
            check(e.name, "jam", {7'b0, jam}, {7'b0, e.jam});
            check(e.name, "sync", {7'b0, sync}, {7'b0, e.timing[0]});
            check(e.name, "int_active", {7'b0, int_active}, {7'b0, e.int_active});
            check(e.name, "vector_sel", {6'b0, vector_sel}, {6'b0, e.vector_sel});
        end
    end

    task automatic step(input string name, input logic rst_n_v, input logic rdy_v, input logic we_v,
                        input logic tr_v, input logic [7:0] din_v, input logic nmi_v, input logic irq_v,
                        input logic ifl_v, input logic [7:0] e_t, input logic [7:0] e_op,
                        input logic e_jam, input logic e_ia, input logic [1:0] e_vs);
        exp_t e;
        @(negedge clock);
        reset_n      = rst_n_v;
        rdy          = rdy_v;
        write_en     = we_v;
        timing_reset = tr_v;
        data_in      = din_v;
        nmi_n        = nmi_v;
        irq_n        = irq_v;
        i_flag       = ifl_v;
        e.name = name; e.timing = e_t; e.opcode = e_op; e.jam = e_jam;
        e.int_active = e_ia; e.vector_sel = e_vs;
        exp_q.push_back(e);
        @(posedge clock);
    endtask

    initial begin
        //    name        rst rdy we tr din   nmi irq ifl  timing op   jam ia vs
        step("reset",      0,  0, 0, 0, 8'h33, 1, 1, 1,   8'h01, 8'hEA, 0, 0, 2'b00);
        step("fetch_a9",   1,  1, 0, 0, 8'hA9, 1, 1, 1,   8'h02, 8'hA9, 0, 0, 2'b00);
        step("t2_treset",  1,  1, 0, 1, 8'hFF, 1, 1, 1,   8'h01, 8'hA9, 0, 0, 2'b00);
        step("fetch_4c",   1,  1, 0, 0, 8'h4C, 1, 1, 1,   8'h02, 8'h4C, 0, 0, 2'b00);
        step("to_t3",      1,  1, 0, 0, 8'h11, 1, 1, 1,   8'h04, 8'h4C, 0, 0, 2'b00);
        step("stall_1",    1,  0, 0, 0, 8'h12, 1, 1, 1,   8'h04, 8'h4C, 0, 0, 2'b00);
        step("stall_2",    1,  0, 0, 0, 8'h13, 1, 1, 1,   8'h04, 8'h4C, 0, 0, 2'b00);
        step("stall_3",    1,  0, 0, 0, 8'h14, 1, 1, 1,   8'h04, 8'h4C, 0, 0, 2'b00);
        step("write_adv",  1,  0, 1, 0, 8'h15, 1, 1, 1,   8'h08, 8'h4C, 0, 0, 2'b00);
        step("to_t5",      1,  1, 0, 0, 8'h16, 1, 1, 1,   8'h10, 8'h4C, 0, 0, 2'b00);
        step("to_t6",      1,  1, 0, 0, 8'h17, 1, 1, 1,   8'h20, 8'h4C, 0, 0, 2'b00);
        step("to_t7",      1,  1, 0, 0, 8'h18, 1, 1, 1,   8'h40, 8'h4C, 0, 0, 2'b00);
        step("to_t8",      1,  1, 0, 0, 8'h19, 1, 1, 1,   8'h80, 8'h4C, 0, 0, 2'b00);
        step("overflow",   1,  1, 0, 0, 8'h1A, 1, 1, 1,   8'h00, 8'h4C, 1, 0, 2'b00);
        step("jam_rdy0",   1,  0, 0, 0, 8'h1B, 1, 1, 1,   8'h00, 8'h4C, 1, 0, 2'b00);
        step("jam_treset", 1,  1, 0, 1, 8'h1C, 1, 1, 1,   8'h00, 8'h4C, 1, 0, 2'b00);
        step("jam_write",  1,  0, 1, 0, 8'h1D, 1, 1, 1,   8'h00, 8'h4C, 1, 0, 2'b00);
        step("jam_reset",  0,  1, 0, 0, 8'h1E, 1, 1, 1,   8'h01, 8'hEA, 0, 0, 2'b00);
        step("t1_stall",   1,  0, 0, 0, 8'h11, 1, 1, 1,   8'h01, 8'hEA, 0, 0, 2'b00);
        step("t1_write",   1,  0, 1, 0, 8'h22, 1, 1, 1,   8'h02, 8'h22, 0, 0, 2'b00);
        step("t2_treset2", 1,  1, 0, 1, 8'h23, 1, 1, 1,   8'h01, 8'h22, 0, 0, 2'b00);
        step("fetch_a9b",  1,  1, 0, 0, 8'hA9, 1, 1, 1,   8'h02, 8'hA9, 0, 0, 2'b00);
`ifdef M6502_INTERRUPT_EN
        // NMI edge during t2 with IRQ also low; NMI wins at the next boundary.
        step("nmi_edge",   1,  1, 0, 1, 8'h55, 0, 0, 0,   8'h01, 8'hA9, 0, 0, 2'b00);
        step("nmi_inject", 1,  1, 0, 0, 8'hA9, 0, 0, 0,   8'h02, 8'h00, 0, 1, 2'b01);
        step("brk_t3",     1,  1, 0, 0, 8'h66, 0, 0, 0,   8'h04, 8'h00, 0, 1, 2'b01);
        step("brk_stall",  1,  0, 0, 0, 8'h67, 0, 0, 0,   8'h04, 8'h00, 0, 1, 2'b01);
        step("brk_end",    1,  1, 0, 1, 8'h68, 0, 0, 0,   8'h01, 8'h00, 0, 0, 2'b00);
        step("irq_inject", 1,  1, 0, 0, 8'hC3, 0, 0, 0,   8'h02, 8'h00, 0, 1, 2'b11);
        step("irq_end",    1,  1, 0, 1, 8'h69, 0, 0, 0,   8'h01, 8'h00, 0, 0, 2'b00);
        step("irq_masked", 1,  1, 0, 0, 8'hC3, 0, 0, 1,   8'h02, 8'hC3, 0, 0, 2'b00);
        step("mask_end",   1,  1, 0, 1, 8'h6A, 1, 0, 1,   8'h01, 8'hC3, 0, 0, 2'b00);
        // Pending NMI is discarded by reset.
        step("nmi_edge2",  1,  0, 0, 0, 8'h6B, 0, 1, 1,   8'h01, 8'hC3, 0, 0, 2'b00);
        step("rst_drop",   0,  0, 0, 0, 8'h6C, 0, 1, 1,   8'h01, 8'hEA, 0, 0, 2'b00);
        step("no_nmi",     1,  1, 0, 0, 8'h5A, 0, 1, 1,   8'h02, 8'h5A, 0, 0, 2'b00);
`else
        // Interrupt inputs have no effect in this build.
        step("nmi_ign_t2", 1,  1, 0, 1, 8'h55, 0, 0, 0,   8'h01, 8'hA9, 0, 0, 2'b00);
        step("nmi_ign_t1", 1,  1, 0, 0, 8'hA5, 0, 0, 0,   8'h02, 8'hA5, 0, 0, 2'b00);
        step("irq_ign_t2", 1,  1, 0, 1, 8'h66, 0, 0, 0,   8'h01, 8'hA5, 0, 0, 2'b00);
        step("irq_ign_t1", 1,  1, 0, 0, 8'hB6, 0, 0, 0,   8'h02, 8'hB6, 0, 0, 2'b00);
        step("ign_t3",     1,  1, 0, 0, 8'h77, 1, 0, 0,   8'h04, 8'hB6, 0, 0, 2'b00);
`endif
        repeat (3) @(posedge clock);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
